// File: rtl/capture_sequencer.sv
// Capture buffer sequencer (arm, prefill, armed, postfill, done, readout); read_valid trails read_addr by one cycle.
// No backpressure: the readout streams without stalling. CAPTURE_TRIGGER_EDGE_EN selects edge over level triggering.
module capture_sequencer #(
  parameter int MEMORY_SIZE  = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int USER_HOLDOFF = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  rd_req,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_valid,
  output logic                  read_last,
  output logic [ADDR_WIDTH-1:0] trigger_addr,
  output logic                  capture_done,
  output logic                  busy
);

  localparam int CNT_W     = ADDR_WIDTH + 1;
  localparam int PRE_DEPTH = MEMORY_SIZE - USER_HOLDOFF - 1;
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_DEPTH - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(USER_HOLDOFF - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(MEMORY_SIZE - 1);
  localparam logic [CNT_W-1:0] RD_END    = CNT_W'(MEMORY_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFILL, S_ARMED, S_POSTFILL, S_DONE, S_READOUT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  read_valid_q, read_valid_d;
  logic                  read_last_q, read_last_d;
  logic                  trig_fire;

`ifdef CAPTURE_TRIGGER_EDGE_EN
  logic trig_prev_q, trig_prev_d;

  always_comb begin
    trig_prev_d = trigger;
  end

  always_ff @(posedge clk) begin
    if (reset) trig_prev_q <= 1'b0;
    else       trig_prev_q <= trig_prev_d;
  end

  assign trig_fire = trigger & ~trig_prev_q;
`else
  assign trig_fire = trigger;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    trig_addr_d  = trig_addr_q;
    cnt_d        = cnt_q;
    read_valid_d = 1'b0;
    read_last_d  = 1'b0;
    write_enable = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_ptr_d = '0;
        cnt_d    = '0;
        if (arm) state_d = S_PREFILL;
      end
      S_PREFILL: begin
        write_enable = 1'b1;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = S_ARMED;
          cnt_d   = '0;
        end
      end
      S_ARMED: begin
        write_enable = 1'b1;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        if (trig_fire) begin
          trig_addr_d = wr_ptr_q;
          cnt_d       = '0;
          state_d     = S_POSTFILL;
        end
      end
      S_POSTFILL: begin
        write_enable = 1'b1;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == POST_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        // the next write location is the oldest surviving sample
        if (rd_req) begin
          rd_ptr_d = wr_ptr_q;
          cnt_d    = '0;
          state_d  = S_READOUT;
        end
      end
      S_READOUT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != RD_END) begin
          rd_ptr_d     = rd_ptr_q + 1'b1;
          read_valid_d = 1'b1;
          read_last_d  = (cnt_q == RD_LAST);
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      trig_addr_q  <= '0;
      cnt_q        <= '0;
      read_valid_q <= 1'b0;
      read_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      trig_addr_q  <= trig_addr_d;
      cnt_q        <= cnt_d;
      read_valid_q <= read_valid_d;
      read_last_q  <= read_last_d;
    end
  end

  assign write_addr   = wr_ptr_q;
  assign read_addr    = rd_ptr_q;
  assign read_valid   = read_valid_q;
  assign read_last    = read_last_q;
  assign trigger_addr = trig_addr_q;
  assign capture_done = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer at MEMORY_SIZE=16, USER_HOLDOFF=4 (level or edge trigger build).
module tb_capture_sequencer;

  logic       clk = 1'b0;
  logic       reset, arm, trigger, rd_req;
  logic       write_enable, read_valid, read_last, capture_done, busy;
  logic [3:0] write_addr, read_addr, trigger_addr;

  int total = 0;
  int bad   = 0;

`ifdef CAPTURE_TRIGGER_EDGE_EN
  localparam int         EARLY_TRIG = 14;
  localparam int         EARLY_DONE = 20;
  localparam logic [3:0] EARLY_OLD  = 4'd3;
`else
  localparam int         EARLY_TRIG = 11;
  localparam int         EARLY_DONE = 17;
  localparam logic [3:0] EARLY_OLD  = 4'd0;
`endif

  capture_sequencer #(
    .MEMORY_SIZE (16),
    .ADDR_WIDTH  (4),
    .USER_HOLDOFF(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .trigger     (trigger),
    .rd_req      (rd_req),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .read_addr   (read_addr),
    .read_valid  (read_valid),
    .read_last   (read_last),
    .trigger_addr(trigger_addr),
    .capture_done(capture_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 1'b0; trigger = 1'b0; rd_req = 1'b0;
    step();
    step();
    total++;
    if ({write_enable, write_addr, read_addr, read_valid, read_last, trigger_addr, capture_done, busy} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b wa=%h ra=%h rv=%b rl=%b ta=%h cd=%b busy=%b, want all 0",
               write_enable, write_addr, read_addr, read_valid, read_last, trigger_addr, capture_done, busy);
    end
    reset  = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (busy !== 1'b0 || read_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_rd_req_ignored: got busy=%b rv=%b, want 0 0", busy, read_valid);
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_basic_capture();
    logic [3:0] exp_wa;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      exp_wa = 4'(c - 1);
      total++;
      if (write_enable !== 1'b1 || write_addr !== exp_wa || busy !== 1'b1 || capture_done !== 1'b0) begin
        bad++;
        $display("FAIL prefill_c%0d: got we=%b wa=%h busy=%b cd=%b, want 1 %h 1 0",
                 c, write_enable, write_addr, busy, capture_done, exp_wa);
      end
      step();
    end
    // cycle 12: ARMED; arm and rd_req must be ignored
    total++;
    if (write_enable !== 1'b1 || write_addr !== 4'd11) begin
      bad++;
      $display("FAIL armed_first: got we=%b wa=%h, want 1 b", write_enable, write_addr);
    end
    arm = 1'b1; rd_req = 1'b1;
    step();
    total++;
    if (write_enable !== 1'b1 || write_addr !== 4'd12 || read_valid !== 1'b0 || capture_done !== 1'b0) begin
      bad++;
      $display("FAIL armed_ignores_ctrl: got we=%b wa=%h rv=%b cd=%b, want 1 c 0 0",
               write_enable, write_addr, read_valid, capture_done);
    end
    arm = 1'b0; rd_req = 1'b0;
    step();
    trigger = 1'b1;
    total++;
    if (write_addr !== 4'd13) begin
      bad++;
      $display("FAIL trigger_cycle_addr: got %h, want d", write_addr);
    end
    step();
    trigger = 1'b0;
    total++;
    if (trigger_addr !== 4'd13) begin
      bad++;
      $display("FAIL trigger_addr: got %h, want d", trigger_addr);
    end
    for (int k = 0; k < 4; k++) begin
      exp_wa = 4'(14 + k);
      total++;
      if (write_enable !== 1'b1 || write_addr !== exp_wa || capture_done !== 1'b0) begin
        bad++;
        $display("FAIL postfill_%0d: got we=%b wa=%h cd=%b, want 1 %h 0", k, write_enable, write_addr, capture_done, exp_wa);
      end
      step();
    end
    total++;
    if (capture_done !== 1'b1 || write_enable !== 1'b0 || write_addr !== 4'd2 || trigger_addr !== 4'd13) begin
      bad++;
      $display("FAIL done_state: got cd=%b we=%b wa=%h ta=%h, want 1 0 2 d", capture_done, write_enable, write_addr, trigger_addr);
    end
    arm = 1'b1;
    step();
    arm = 1'b0;
    total++;
    if (capture_done !== 1'b1 || busy !== 1'b1 || read_valid !== 1'b0 || write_addr !== 4'd2) begin
      bad++;
      $display("FAIL done_ignores_arm: got cd=%b busy=%b rv=%b wa=%h, want 1 1 0 2", capture_done, busy, read_valid, write_addr);
    end
  endtask

  task automatic test_readout(input logic [3:0] oldest);
    logic [3:0] exp_ra;
    int         pulses;
    pulses = 0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      exp_ra = oldest + i[3:0];
      total++;
      if ((i < 16 && read_addr !== exp_ra) || read_valid !== (i >= 1) || read_last !== (i == 16) ||
          busy !== 1'b1 || capture_done !== 1'b0) begin
        bad++;
        $display("FAIL readout_%h_i%0d: got ra=%h rv=%b rl=%b busy=%b cd=%b, want ra=%h rv=%b rl=%b busy=1 cd=0",
                 oldest, i, read_addr, read_valid, read_last, busy, capture_done, exp_ra, (i >= 1), (i == 16));
      end
      if (read_valid === 1'b1) pulses++;
      step();
    end
    total++;
    if (busy !== 1'b0 || read_valid !== 1'b0 || read_last !== 1'b0) begin
      bad++;
      $display("FAIL readout_end: got busy=%b rv=%b rl=%b, want 0 0 0", busy, read_valid, read_last);
    end
    total++;
    if (pulses != 16) begin
      bad++;
      $display("FAIL readout_pulses: got %0d, want 16", pulses);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_wa;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int c = 1; c <= 11; c++) step();
    for (int k = 0; k < 40; k++) begin
      exp_wa = 4'(11 + k);
      total++;
      if (write_enable !== 1'b1 || write_addr !== exp_wa || capture_done !== 1'b0) begin
        bad++;
        $display("FAIL wrap_armed_%0d: got we=%b wa=%h cd=%b, want 1 %h 0", k, write_enable, write_addr, capture_done, exp_wa);
      end
      step();
    end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    total++;
    if (trigger_addr !== 4'd3) begin
      bad++;
      $display("FAIL wrap_trigger_addr: got %h, want 3", trigger_addr);
    end
    for (int k = 0; k < 4; k++) step();
    total++;
    if (capture_done !== 1'b1 || write_addr !== 4'd8) begin
      bad++;
      $display("FAIL wrap_done: got cd=%b wa=%h, want 1 8", capture_done, write_addr);
    end
  endtask

  task automatic test_early_trigger();
    arm = 1'b1; trigger = 1'b1;
    step();
    arm = 1'b0;
    for (int c = 1; c <= EARLY_DONE; c++) begin
      if (c == 14) trigger = 1'b0;
      if (c == 15) trigger = 1'b1;
      if (c == 16) trigger = 1'b0;
      if (c == 11) begin
        total++;
        if (write_enable !== 1'b1 || write_addr !== 4'd10 || capture_done !== 1'b0) begin
          bad++;
          $display("FAIL early_last_prefill: got we=%b wa=%h cd=%b, want 1 a 0", write_enable, write_addr, capture_done);
        end
      end
      if (c == EARLY_DONE - 1) begin
        total++;
        if (capture_done !== 1'b0 || write_enable !== 1'b1) begin
          bad++;
          $display("FAIL early_before_done: got cd=%b we=%b, want 0 1", capture_done, write_enable);
        end
      end
      if (c == EARLY_DONE) begin
        total++;
        if (capture_done !== 1'b1 || trigger_addr !== 4'(EARLY_TRIG) || write_addr !== EARLY_OLD) begin
          bad++;
          $display("FAIL early_done: got cd=%b ta=%h wa=%h, want 1 %h %h",
                   capture_done, trigger_addr, write_addr, 4'(EARLY_TRIG), EARLY_OLD);
        end
      end
      if (c < EARLY_DONE) step();
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; arm = 1'b0; trigger = 1'b0; rd_req = 1'b0;
    step();
    reset = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int c = 1; c < 12; c++) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    // cycle 14: mid-POSTFILL
    reset = 1'b1;
    step();
    total++;
    if ({write_enable, write_addr, read_addr, read_valid, read_last, trigger_addr, capture_done, busy} !== 17'd0) begin
      bad++;
      $display("FAIL reset_in_postfill: got we=%b wa=%h ra=%h rv=%b rl=%b ta=%h cd=%b busy=%b, want all 0",
               write_enable, write_addr, read_addr, read_valid, read_last, trigger_addr, capture_done, busy);
    end
    reset = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    total++;
    if (write_enable !== 1'b1 || write_addr !== 4'd0) begin
      bad++;
      $display("FAIL restart_addr: got we=%b wa=%h, want 1 0", write_enable, write_addr);
    end
    for (int c = 1; c < 12; c++) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int c = 13; c < 17; c++) step();
    total++;
    if (capture_done !== 1'b1 || write_addr !== 4'd0 || trigger_addr !== 4'd11) begin
      bad++;
      $display("FAIL restart_done: got cd=%b wa=%h ta=%h, want 1 0 b", capture_done, write_addr, trigger_addr);
    end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (read_valid !== 1'b1 || read_addr !== 4'd5) begin
      bad++;
      $display("FAIL mid_readout: got rv=%b ra=%h, want 1 5", read_valid, read_addr);
    end
    reset = 1'b1;
    step();
    total++;
    if ({write_enable, write_addr, read_addr, read_valid, read_last, trigger_addr, capture_done, busy} !== 17'd0) begin
      bad++;
      $display("FAIL reset_in_readout: got we=%b wa=%h ra=%h rv=%b rl=%b ta=%h cd=%b busy=%b, want all 0",
               write_enable, write_addr, read_addr, read_valid, read_last, trigger_addr, capture_done, busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (read_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_quiet: got rv=%b busy=%b, want 0 0", read_valid, busy);
      end
    end
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; trigger = 1'b0; rd_req = 1'b0;
    test_reset();
    test_basic_capture();
    test_readout(4'd2);
    test_wrap();
    test_readout(4'd8);
    test_early_trigger();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences the analyzer's circular capture buffer: arm, pre-trigger fill, wait for trigger, post-trigger holdoff, freeze, then stream-out.
- Drives the buffer's write enable and write/read addresses; the buffer itself, the probe mux and the data checker are outside this block.
- Sits between the user control interface (arm/trigger/readout request) and the single-port-write / single-port-read capture RAM (1-cycle read latency).

Parameters:
- MEMORY_SIZE, 16, buffer depth in samples; power of two, >= 4.
- ADDR_WIDTH, 4, log2(MEMORY_SIZE).
- USER_HOLDOFF, 4, post-trigger samples written after the trigger sample; legal range 1..MEMORY_SIZE-2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- arm  input  1  start a capture; sampled only in IDLE.
- trigger  input  1  trigger qualifier from trigger logic.
- rd_req  input  1  readout request; sampled only in DONE.
- write_enable  output  1  buffer write strobe.
- write_addr  output  ADDR_WIDTH  buffer write address.
- read_addr  output  ADDR_WIDTH  buffer read address.
- read_valid  output  1  buffer output is a valid captured sample this cycle.
- read_last  output  1  qualifies the final sample of a readout, together with read_valid.
- trigger_addr  output  ADDR_WIDTH  address holding the trigger sample.
- capture_done  output  1  capture frozen and awaiting readout.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, PREFILL, ARMED, POSTFILL, DONE, READOUT. Encoding is free.
- Reset: state=IDLE; all outputs 0; write/read pointers and counters 0. Reset mid-operation aborts immediately, with no partial readout.
- IDLE: arm=1 -> PREFILL next cycle. write_addr reloads to 0 on entry.
- PREFILL:
  - write_enable=1 every cycle; write_addr increments modulo MEMORY_SIZE after each write.
  - After PRE_DEPTH = MEMORY_SIZE-USER_HOLDOFF-1 writes -> ARMED.
  - trigger is ignored in PREFILL, so the pre-trigger history is guaranteed full.
- ARMED:
  - write_enable=1 every cycle; write_addr wraps freely.
  - On a cycle where the trigger condition is true, the write in that cycle is the trigger sample.
  - trigger_addr latches that cycle's write_addr; next state is POSTFILL.
- POSTFILL:
  - write_enable=1 for exactly USER_HOLDOFF cycles, then DONE.
  - trigger is ignored in POSTFILL.
- DONE:
  - write_enable=0; capture_done=1.
  - The oldest sample address is write_addr (next write location, already wrapped).
  - rd_req=1 -> READOUT; read_addr loads the oldest address on the transition. arm is ignored in DONE.
- READOUT:
  - read_addr increments modulo MEMORY_SIZE each cycle for MEMORY_SIZE cycles.
  - read_valid is asserted one cycle after each read_addr value is presented (RAM latency). Exactly MEMORY_SIZE read_valid pulses, contiguous.
  - read_last=1 with the MEMORY_SIZE-th read_valid.
  - Return to IDLE the cycle after read_last. capture_done deasserts on entry to READOUT.
  - rd_req deasserting mid-readout does not stall the stream.
- Simultaneous events:
  - arm and trigger in the same IDLE cycle: arm only.
  - trigger on the final PREFILL write: ignored; the first eligible trigger is the first ARMED cycle.
  - reset has priority over all.
- Counters: pointer arithmetic is ADDR_WIDTH bits with natural wrap. The sample counter is sized to hold MEMORY_SIZE.

Optional Feature:
- Macro: CAPTURE_TRIGGER_EDGE_EN.
- Defined:
  - trigger condition in ARMED = rising edge (trigger=1 and registered previous trigger=0).
  - The previous-trigger register resets to 0 and updates every cycle in every state. A trigger already high on ARMED entry therefore does not fire until it drops and rises again.
- Undefined:
  - trigger condition in ARMED = level (trigger=1).
  - No edge register is synthesized.

Test Plan:
- Basic capture (MEMORY_SIZE=16, USER_HOLDOFF=4): arm pulse at cycle 0 -> write_enable high cycles 1..11 at addr 0..10 (PRE_DEPTH=11), ARMED from cycle 12; trigger at cycle 14 (addr 13) -> trigger_addr=13, POSTFILL writes addr 14,15,0,1; capture_done=1 next cycle; write_addr=2.
- Readout ordering: from the previous state, pulse rd_req -> read_addr sequence 2..15,0,1; 16 read_valid pulses starting one cycle after the first read_addr; read_last on the 16th (sample at addr 1); busy=0 the cycle after.
- Early trigger ignored: trigger held high from cycle 0 after arm -> no capture until ARMED. Level build fires on the first ARMED cycle (trigger_addr=11). Edge build waits until trigger falls and rises again.
- Wrap in ARMED: no trigger for 40 cycles, then trigger -> trigger_addr equals (cycles written -1) mod 16; oldest address = trigger_addr+USER_HOLDOFF+1 mod 16.
- Reset mid-operation: assert reset during POSTFILL and during READOUT -> next cycle state IDLE, all outputs 0; a subsequent arm restarts at write_addr 0.
- Ignored controls: arm during ARMED/DONE and rd_req during IDLE/ARMED -> no state change, no spurious read_valid.
